regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Architectural integer register file (x0–x31) for the RV32I core.
- Sits on the receiving end of the execute stage: the ALU result (and load data) is written back here, and this block also supplies the rs1/rs2 operands that the execute stage consumes.
- Tracks in-flight destination registers with a per-register pending counter and raises a stall when a read hits a register that is still pending.

Parameters:
- DWIDTH, 32, register data width.
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5.
- SP_INIT, 32'h0100_0000, reset value of x2 (sp).
- PEND_W, 2, width of each pending counter; the maximum number of in-flight writes to one register is 2^PEND_W - 1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- rs1_addr_i, input, 5, read port 1 index.
- rs2_addr_i, input, 5, read port 2 index.
- rs1_data_o, output, DWIDTH, read port 1 data.
- rs2_data_o, output, DWIDTH, read port 2 data.
- rd_check_i, input, 2, per-port "operand actually used" flags; [0] = rs1, [1] = rs2.
- issue_valid_i, input, 1, an instruction is leaving decode this cycle.
- issue_regwren_i, input, 1, the issuing instruction writes rd.
- issue_rd_i, input, 5, destination of the issuing instruction.
- wb_valid_i, input, 1, writeback this cycle.
- wb_rd_i, input, 5, writeback destination.
- wb_data_i, input, DWIDTH, writeback data (ALU res_o or load data).
- stall_o, output, 1, operand hazard: decode must hold.
- err_o, output, 1, sticky scoreboard error flag.

Behaviour:

Reset (asynchronous, active-high):
- Every register is cleared to 0, except x2, which is loaded with SP_INIT.
- All pending counters are cleared to 0 and err_o is cleared to 0.
- stall_o falls to 0 combinationally once the counters clear.
- A reset asserted mid-operation discards all pending state immediately; any writeback that arrives after reset deasserts is applied normally to the register contents.

Reads (combinational):
- Reading x0 always returns 0.
- Write-through bypass: if wb_valid_i is high, wb_rd_i equals the read index, and wb_rd_i is not 0, the read returns wb_data_i in the same cycle.
- Otherwise the read returns the stored register value.

Writes:
- On the clock edge, when wb_valid_i is high and wb_rd_i is not 0, the register at wb_rd_i is loaded with wb_data_i.
- Writes to x0 are ignored; x0 is never updated.

Pending counters (pend[r], r = 1..31):
- pend[0] is constant 0.
- An issue event on r is issue_valid_i & issue_regwren_i & (issue_rd_i == r) & ~stall_o. On an issue event, pend[r] increments by 1.
- A writeback event on r is wb_valid_i & (wb_rd_i == r). On a writeback event, pend[r] decrements by 1.
- If the issue event and the writeback event hit the same r in the same cycle, pend[r] is unchanged.
- Overflow: an issue event with pend[r] at its maximum (2^PEND_W - 1) leaves pend[r] saturated and sets err_o.
- Underflow: a writeback event with pend[r] = 0 still writes the data, leaves pend[r] at 0, and sets err_o.
- err_o stays high until the next reset.

Stall (combinational):
- hazard1 = rd_check_i[0] & (rs1_addr_i != 0) & (pend[rs1] != 0) & ~(wb_valid_i & wb_rd_i == rs1_addr_i & pend[rs1] == 1).
- hazard2 is the same expression using rs2_addr_i and rd_check_i[1].
- stall_o = hazard1 | hazard2.
- A writeback that retires the last outstanding write to a register unblocks the read in the same cycle; the bypass supplies the data.
- While stall_o is high, issue events are suppressed internally, so a stalled instruction does not increment any counter.

Latency:
- Read: 0 cycles.
- Write: visible through the bypass in the same cycle, and stored from the next cycle.
- Scoreboard update: takes effect on the next edge.

Test Plan:
- Reset: assert reset, then read x0, x2, x5 -> 0, 32'h0100_0000, 0; stall_o = 0; err_o = 0.
- Write then read: wb x5 = 32'hDEAD_BEEF while reading rs1 = 5 in the same cycle -> rs1_data_o = 32'hDEAD_BEEF (bypass). Read again the next cycle -> still 32'hDEAD_BEEF. Then wb x0 = 32'h1234 -> x0 reads 0.
- RAW hazard: issue rd = 7; next cycle read rs2 = 7 with rd_check_i = 2'b10 -> stall_o = 1. In the cycle that wb x7 = 32'h42 arrives -> stall_o = 0 and rs2_data_o = 32'h42. Repeat with rd_check_i = 2'b00 -> stall_o = 0 throughout.
- Multiple in flight: issue rd = 3 twice, then wb x3 once -> read of x3 still stalls (pend = 1). Second wb -> stall clears. Issue and wb on x3 in the same cycle with pend = 1 -> pend stays 1.
- Errors: wb x9 with pend[9] = 0 -> err_o = 1 and x9 is still written. Issue rd = 4 four times with PEND_W = 2 -> err_o = 1 and the counter stays at 3. err_o persists until reset.
- Reset mid-flight: issue rd = 6, assert reset asynchronously between clock edges -> pend[6] = 0 and stall_o = 0 immediately. A subsequent wb x6 after reset -> err_o = 1.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Operand-read, issue and writeback signals between decode/execute and the
// RV32I integer register file with its pending-write scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
);
    logic [AWIDTH-1:0] rs1_addr_i;
    logic [AWIDTH-1:0] rs2_addr_i;
    logic [DWIDTH-1:0] rs1_data_o;
    logic [DWIDTH-1:0] rs2_data_o;
    logic [1:0]        rd_check_i;
    logic              issue_valid_i;
    logic              issue_regwren_i;
    logic [AWIDTH-1:0] issue_rd_i;
    logic              wb_valid_i;
    logic [AWIDTH-1:0] wb_rd_i;
    logic [DWIDTH-1:0] wb_data_i;
    logic              stall_o;
    logic              err_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, rd_check_i,
        output issue_valid_i, issue_regwren_i, issue_rd_i,
        output wb_valid_i, wb_rd_i, wb_data_i,
        input  rs1_data_o, rs2_data_o, stall_o, err_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, rd_check_i,
        input  issue_valid_i, issue_regwren_i, issue_rd_i,
        input  wb_valid_i, wb_rd_i, wb_data_i,
        output rs1_data_o, rs2_data_o, stall_o, err_o
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// RV32I architectural register file with write-through bypass and a
// per-register pending-write counter that stalls reads of in-flight results.
module regfile_scoreboard #(
    parameter int unsigned       DWIDTH  = 32,
    parameter int unsigned       NREGS   = 32,
    parameter logic [DWIDTH-1:0] SP_INIT = 32'h0100_0000,
    parameter int unsigned       PEND_W  = 2
) (
    input logic                clk,
    input logic                reset,
    regfile_scoreboard_if.slave bus
);

    localparam int unsigned       AW       = $clog2(NREGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DWIDTH-1:0] regs      [NREGS];
    logic [PEND_W-1:0] pend      [NREGS];
    logic [PEND_W-1:0] pend_next [NREGS];
    logic [NREGS-1:0]  inc_hit;
    logic [NREGS-1:0]  dec_hit;
    logic              err;
    logic              err_hit;
    logic              hazard1;
    logic              hazard2;
    logic              stall;
    logic              issue_fire;

    function automatic logic [DWIDTH-1:0] read_port(
        input logic [AW-1:0]     addr,
        input logic              wb_valid,
        input logic [AW-1:0]     wb_rd,
        input logic [DWIDTH-1:0] wb_data,
        input logic [DWIDTH-1:0] stored
    );
        if (addr == '0)
            return '0;
        else if (wb_valid && (wb_rd == addr))
            return wb_data;
        else
            return stored;
    endfunction

    // A writeback retiring the last outstanding write releases the read at once.
    function automatic logic hazard(
        input logic              used,
        input logic [AW-1:0]     addr,
        input logic [PEND_W-1:0] cnt,
        input logic              wb_valid,
        input logic [AW-1:0]     wb_rd
    );
        return used && (addr != '0) && (cnt != '0)
            && !(wb_valid && (wb_rd == addr) && (cnt == PEND_ONE));
    endfunction

    assign bus.rs1_data_o = read_port(bus.rs1_addr_i, bus.wb_valid_i, bus.wb_rd_i,
                                      bus.wb_data_i, regs[bus.rs1_addr_i]);
    assign bus.rs2_data_o = read_port(bus.rs2_addr_i, bus.wb_valid_i, bus.wb_rd_i,
                                      bus.wb_data_i, regs[bus.rs2_addr_i]);
    assign bus.stall_o    = stall;
    assign bus.err_o      = err;

    always_comb begin
        hazard1    = hazard(bus.rd_check_i[0], bus.rs1_addr_i, pend[bus.rs1_addr_i],
                            bus.wb_valid_i, bus.wb_rd_i);
        hazard2    = hazard(bus.rd_check_i[1], bus.rs2_addr_i, pend[bus.rs2_addr_i],
                            bus.wb_valid_i, bus.wb_rd_i);
        stall      = hazard1 | hazard2;
        issue_fire = bus.issue_valid_i & bus.issue_regwren_i & ~stall;
    end

    always_comb begin
        inc_hit      = '0;
        dec_hit      = '0;
        err_hit      = 1'b0;
        pend_next[0] = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc_hit[r]   = issue_fire && (bus.issue_rd_i == AW'(r));
            dec_hit[r]   = bus.wb_valid_i && (bus.wb_rd_i == AW'(r));
            pend_next[r] = pend[r];
            if (inc_hit[r] && !dec_hit[r]) begin
                if (pend[r] == PEND_MAX)
                    err_hit = 1'b1;
                else
                    pend_next[r] = pend[r] + PEND_ONE;
            end else if (dec_hit[r] && !inc_hit[r]) begin
                if (pend[r] == '0)
                    err_hit = 1'b1;
                else
                    pend_next[r] = pend[r] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++)
                pend[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++)
                pend[r] <= pend_next[r];
            err <= err | err_hit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++)
                regs[r] <= (r == 2) ? SP_INIT : '0;
        end else if (bus.wb_valid_i && (bus.wb_rd_i != '0)) begin
            regs[bus.wb_rd_i] <= bus.wb_data_i;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test-plan steps followed by randomized traffic, each cycle checked
// against an array/counter reference model of the register file and scoreboard.
module tb_regfile_scoreboard;

    localparam logic [31:0] SP_INIT  = 32'h0100_0000;
    localparam int          PEND_MAX = 3;

    logic clk = 1'b0;
    logic reset;

    regfile_scoreboard_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

    regfile_scoreboard #(
        .DWIDTH (32),
        .NREGS  (32),
        .SP_INIT(SP_INIT),
        .PEND_W (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] m_rf   [32];
    int          m_pend [32];
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_rf[r]   = 32'h0;
            m_pend[r] = 0;
        end
        m_rf[2] = SP_INIT;
        m_err   = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.wb_valid_i && bus.wb_rd_i == a) return bus.wb_data_i;
        return m_rf[a];
    endfunction

    function automatic bit m_port_blocked(input bit used, input logic [4:0] a);
        if (!used || a == 5'd0 || m_pend[a] == 0) return 1'b0;
        if (bus.wb_valid_i && bus.wb_rd_i == a && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return m_port_blocked(bus.rd_check_i[0], bus.rs1_addr_i)
            || m_port_blocked(bus.rd_check_i[1], bus.rs2_addr_i);
    endfunction

    task automatic check_model();
        check("rs1_data", bus.rs1_data_o, m_read(bus.rs1_addr_i));
        check("rs2_data", bus.rs2_data_o, m_read(bus.rs2_addr_i));
        check("stall",    {31'b0, bus.stall_o}, {31'b0, m_stall()});
        check("err",      {31'b0, bus.err_o},   {31'b0, m_err});
    endtask

    // Called just after a falling edge; leaves time to sample before the rising edge.
    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] chk,
                         input logic iv, input logic iw, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        bus.rs1_addr_i      = r1;
        bus.rs2_addr_i      = r2;
        bus.rd_check_i      = chk;
        bus.issue_valid_i   = iv;
        bus.issue_regwren_i = iw;
        bus.issue_rd_i      = ird;
        bus.wb_valid_i      = wv;
        bus.wb_rd_i         = wrd;
        bus.wb_data_i       = wd;
        #2;
        check_model();
    endtask

    task automatic tick();
        bit st;
        bit fire;
        int delta;
        st   = m_stall();
        fire = bus.issue_valid_i && bus.issue_regwren_i && !st;
        for (int r = 1; r < 32; r++) begin
            delta = ((fire && bus.issue_rd_i == r) ? 1 : 0)
                  - ((bus.wb_valid_i && bus.wb_rd_i == r) ? 1 : 0);
            if (delta == 1) begin
                if (m_pend[r] == PEND_MAX) m_err = 1'b1;
                else m_pend[r]++;
            end else if (delta == -1) begin
                if (m_pend[r] == 0) m_err = 1'b1;
                else m_pend[r]--;
            end
        end
        if (bus.wb_valid_i && bus.wb_rd_i != 5'd0) m_rf[bus.wb_rd_i] = bus.wb_data_i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        bus.issue_valid_i = 1'b0;
        bus.wb_valid_i    = 1'b0;
        #1 reset = 1'b1;
        #1 model_reset();
        check_model();
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        @(negedge clk);

        drive(5'd0, 5'd2, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("rst_x0", bus.rs1_data_o, 32'h0);
        check("rst_x2", bus.rs2_data_o, SP_INIT);
        check("rst_stall", {31'b0, bus.stall_o}, 32'h0);
        check("rst_err", {31'b0, bus.err_o}, 32'h0);
        drive(5'd5, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("rst_x5", bus.rs1_data_o, 32'h0);
        reset = 1'b0;
        tick();

        drive(5'd5, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF);
        check("bypass_x5", bus.rs1_data_o, 32'hDEAD_BEEF);
        tick();
        drive(5'd5, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("stored_x5", bus.rs1_data_o, 32'hDEAD_BEEF);
        check("underflow_x5_err", {31'b0, bus.err_o}, 32'h1);
        tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd0, 32'h1234);
        check("x0_bypass", bus.rs1_data_o, 32'h0);
        tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("x0_stored", bus.rs1_data_o, 32'h0);
        pulse_reset();

        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd7, 0, 5'd0, 32'h0); tick();
        drive(5'd0, 5'd7, 2'b10, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("raw_stall", {31'b0, bus.stall_o}, 32'h1);
        tick();
        drive(5'd0, 5'd7, 2'b10, 0, 0, 5'd0, 1, 5'd7, 32'h42);
        check("raw_release", {31'b0, bus.stall_o}, 32'h0);
        check("raw_bypass", bus.rs2_data_o, 32'h42);
        tick();
        drive(5'd0, 5'd7, 2'b10, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("raw_after", {31'b0, bus.stall_o}, 32'h0);
        tick();
        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd7, 0, 5'd0, 32'h0); tick();
        drive(5'd0, 5'd7, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("unused_no_stall", {31'b0, bus.stall_o}, 32'h0);
        tick();
        drive(5'd0, 5'd7, 2'b00, 0, 0, 5'd0, 1, 5'd7, 32'h43); tick();

        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd3, 0, 5'd0, 32'h0); tick();
        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd3, 0, 5'd0, 32'h0); tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd3, 32'h33); tick();
        drive(5'd3, 5'd0, 2'b01, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("multi_still_pending", {31'b0, bus.stall_o}, 32'h1);
        tick();
        drive(5'd3, 5'd0, 2'b01, 0, 0, 5'd0, 1, 5'd3, 32'h34);
        check("multi_last_wb", {31'b0, bus.stall_o}, 32'h0);
        check("multi_bypass", bus.rs1_data_o, 32'h34);
        tick();
        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd3, 0, 5'd0, 32'h0); tick();
        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd3, 1, 5'd3, 32'h35); tick();
        drive(5'd3, 5'd0, 2'b01, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("same_cycle_hold", {31'b0, bus.stall_o}, 32'h1);
        tick();
        drive(5'd3, 5'd0, 2'b01, 0, 0, 5'd0, 1, 5'd3, 32'h36);
        check("same_cycle_release", {31'b0, bus.stall_o}, 32'h0);
        tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("balanced_no_err", {31'b0, bus.err_o}, 32'h0);
        tick();

        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd9, 32'h99); tick();
        drive(5'd9, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("underflow_err", {31'b0, bus.err_o}, 32'h1);
        check("underflow_written", bus.rs1_data_o, 32'h99);
        tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("err_sticky", {31'b0, bus.err_o}, 32'h1);
        pulse_reset();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("err_cleared", {31'b0, bus.err_o}, 32'h0);
        tick();

        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd4, 0, 5'd0, 32'h0); tick();
        end
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("at_max_no_err", {31'b0, bus.err_o}, 32'h0);
        tick();
        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd4, 0, 5'd0, 32'h0); tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("overflow_err", {31'b0, bus.err_o}, 32'h1);
        tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd4, 32'h41); tick();
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd4, 32'h42); tick();
        drive(5'd4, 5'd0, 2'b01, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("saturated_pending", {31'b0, bus.stall_o}, 32'h1);
        tick();
        drive(5'd4, 5'd0, 2'b01, 0, 0, 5'd0, 1, 5'd4, 32'h44);
        check("saturated_release", {31'b0, bus.stall_o}, 32'h0);
        tick();
        pulse_reset();

        drive(5'd0, 5'd0, 2'b00, 1, 1, 5'd6, 0, 5'd0, 32'h0); tick();
        drive(5'd6, 5'd0, 2'b01, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("midflight_stall", {31'b0, bus.stall_o}, 32'h1);
        bus.issue_valid_i = 1'b0;
        #1 reset = 1'b1;
        #1 check("midflight_async_clear", {31'b0, bus.stall_o}, 32'h0);
        model_reset();
        check_model();
        reset = 1'b0;
        @(negedge clk);
        drive(5'd0, 5'd0, 2'b00, 0, 0, 5'd0, 1, 5'd6, 32'h66); tick();
        drive(5'd6, 5'd0, 2'b00, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        check("post_reset_underflow", {31'b0, bus.err_o}, 32'h1);
        check("post_reset_written", bus.rs1_data_o, 32'h66);
        tick();

        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 59) == 0) pulse_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
